up_dn_cntr: RTL and testbench



---
 rtl/up_dn_cntr_pkg.sv | 6 +
 rtl/up_dn_cntr_next.sv | 14 +
 rtl/up_dn_cntr.sv | 23 ++
 tb/tb_up_dn_cntr.sv | 76 +++++++
 4 files changed

// File: rtl/up_dn_cntr_pkg.sv
// up_dn_cntr_pkg: shared width default and direction encodings for the up/down counter
package up_dn_cntr_pkg;
  localparam int CNT_WIDTH_DEFAULT = 4;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/up_dn_cntr_next.sv
// up_dn_cntr_next: combinational next count, wrapping naturally modulo 2^WIDTH
module up_dn_cntr_next
  import up_dn_cntr_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             up_dnb_i,
  output logic [WIDTH-1:0] nxt_o
);
  always_comb begin
    nxt_o = (up_dnb_i == DIR_UP) ? cnt_i + WIDTH'(1) : cnt_i - WIDTH'(1);
  end
endmodule

// File: rtl/up_dn_cntr.sv
// up_dn_cntr: free-running up/down counter with synchronous active-high reset
module up_dn_cntr
  import up_dn_cntr_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_dnb,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  up_dn_cntr_next #(.WIDTH(WIDTH)) u_next (
    .cnt_i   (cnt_q),
    .up_dnb_i(up_dnb),
    .nxt_o   (cnt_d)
  );
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: tb/tb_up_dn_cntr.sv
// tb_up_dn_cntr: directed vectors with hand-computed counts plus a toggling-direction model run
module tb_up_dn_cntr;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_dnb = 1'b1;
  logic [3:0] cnt;
  int vectors = 0;
  int miscompares = 0;

  up_dn_cntr #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .up_dnb(up_dnb),
    .cnt   (cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] e);
    vectors++;
    assert (cnt === e) else begin
      miscompares++;
      $error("FAIL %s: cnt=%0d expected=%0d", tag, cnt, e);
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [3:0] e, input string tag);
    reset = r;
    up_dnb = d;
    @(posedge clk);
    #1;
    chk(tag, e);
  endtask

  initial begin
    logic [3:0] exp_cnt;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'd0, "reset_hold");
    for (int i = 1; i <= 14; i++) step(1'b0, 1'b1, 4'(i), "count_up");
    step(1'b0, 1'b1, 4'd15, "up_wrap_15");
    step(1'b0, 1'b1, 4'd0, "up_wrap_0");
    step(1'b0, 1'b1, 4'd1, "up_wrap_1");
    for (int i = 2; i <= 7; i++) step(1'b0, 1'b1, 4'(i), "up_to_7");
    step(1'b0, 1'b0, 4'd6, "toggle_dn_6");
    step(1'b0, 1'b0, 4'd5, "toggle_dn_5");
    step(1'b0, 1'b1, 4'd6, "toggle_up_6");
    step(1'b0, 1'b1, 4'd7, "toggle_up_7");
    for (int i = 6; i >= 1; i--) step(1'b0, 1'b0, 4'(i), "down_to_1");
    step(1'b0, 1'b0, 4'd0, "dn_wrap_0");
    step(1'b0, 1'b0, 4'd15, "dn_wrap_15");
    step(1'b0, 1'b0, 4'd14, "dn_wrap_14");
    for (int i = 13; i >= 9; i--) step(1'b0, 1'b0, 4'(i), "down_to_9");
    step(1'b1, 1'b0, 4'd0, "mid_reset");
    step(1'b0, 1'b0, 4'd15, "post_reset_dn");
    exp_cnt = 4'd15;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          #501;
          up_dnb = ~up_dnb;
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          logic d;
          @(posedge clk);
          d = up_dnb;
          #1;
          exp_cnt = d ? exp_cnt + 4'd1 : exp_cnt - 4'd1;
          chk("long_run", exp_cnt);
        end
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
